// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned/two's-complement subtractor, diff = a - b mod 2^WIDTH.
// Latency: WIDTH RUN cycles after the accepting edge, then a one-cycle done pulse (DONE).
// Backpressure: none; start is only honoured in IDLE or DONE and ignored while busy.
//
// Ports:
//   clk        - single clock, all state updates on its rising edge
//   rst_n      - asynchronous active-low reset
//   start      - request a subtraction; a/b are sampled on the accepting edge only
//   a, b       - minuend / subtrahend, WIDTH bits
//   busy       - high while the serial loop is running
//   done       - one-cycle completion pulse
//   diff       - a - b modulo 2^WIDTH, held until the next completion
//   borrow_out - final borrow (unsigned a < b), held with diff
//   ovf        - signed overflow of a - b; present only when SERIAL_SUB_OVF_EN is defined
//
// Optional feature macro: SERIAL_SUB_OVF_EN (adds the ovf port and its logic).

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Counter must be able to represent WIDTH; it wraps to 0 on the final bit.
   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;

   logic             w_load;        // accept a new operation this edge
   logic             w_step;        // process one bit this edge
   logic             w_last;        // this edge processes the MSB

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_bw;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;

   logic             w_a0;
   logic             w_b0;
   logic             w_d;
   logic             w_bw_next;
   logic [WIDTH-1:0] w_res_next;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and control strobes
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next_state = S_RUN;
               w_load       = 1'b1;
            end
         end
         S_RUN: begin
            // start is deliberately not looked at here: requests in flight are ignored.
            w_step = 1'b1;
            if (r_cnt == LAST_BIT) begin
               w_last       = 1'b1;
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               w_next_state = S_RUN;
               w_load       = 1'b1;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // One full-subtractor cell, applied to the current LSBs
   // ------------------------------------------------------------------
   assign w_a0      = r_a[0];
   assign w_b0      = r_b[0];
   assign w_d       = w_a0 ^ w_b0 ^ r_bw;
   assign w_bw_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_bw);

   // Difference bits enter at the MSB so that after WIDTH steps the
   // register holds the result in natural bit order.
   assign w_res_next = (r_res >> 1) | {w_d, {(WIDTH-1){1'b0}}};

   // ------------------------------------------------------------------
   // Working datapath: operand shifters, result shifter, borrow, counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_res <= '0;
         r_bw  <= 1'b0;
         r_cnt <= '0;
      end else if (w_load) begin
         r_a   <= a;
         r_b   <= b;
         r_bw  <= 1'b0;
         r_cnt <= '0;
      end else if (w_step) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_res <= w_res_next;
         r_bw  <= w_bw_next;
         r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Result registers: written only on the edge that enters DONE, so
   // they stay stable through RUN and across idle periods.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else if (w_last) begin
         r_diff   <= w_res_next;
         r_borrow <= w_bw_next;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // The operand MSBs are shifted out during RUN, so keep copies of the
   // sign bits taken on the accepting edge for the overflow test.
   logic r_a_msb;
   logic r_b_msb;
   logic r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
      end else if (w_load) begin
         r_a_msb <= a[WIDTH-1];
         r_b_msb <= b[WIDTH-1];
      end
   end

   // Overflow: operands of opposite sign and result sign differs from a.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_last) begin
         r_ovf <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
      end
   end

   assign ovf = r_ovf;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign busy       = (r_state == S_RUN);
   assign done       = (r_state == S_DONE);
   assign diff       = r_diff;
   assign borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized self-checking bench for serial_subtractor (WIDTH=8).
// Expected results come from plain integer arithmetic on the operands.
// Optional ovf checks are compiled in when SERIAL_SUB_OVF_EN is defined.

module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int errors = 0;
   int checks = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] m_diff(input int x, input int y);
      int r;
      r = (x - y) & ((1 << W) - 1);
      return r[W-1:0];
   endfunction

   function automatic logic m_borrow(input int x, input int y);
      return (x < y);
   endfunction

   function automatic logic m_ovf(input int x, input int y);
      int sx, sy, r;
      sx = (x >= (1 << (W-1))) ? x - (1 << W) : x;
      sy = (y >= (1 << (W-1))) ? y - (1 << W) : y;
      r  = sx - sy;
      return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
   endfunction

   function automatic logic get_ovf();
`ifdef SERIAL_SUB_OVF_EN
      return ovf;
`else
      return 1'b0;
`endif
   endfunction

   // Stimulus driver: one operation with start pulsed for the accept edge.
   // lat counts rising edges from the accept edge (inclusive) until done is seen.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         output int lat, output int busy_cnt,
                         output logic [W-1:0] r_diff, output logic r_bw,
                         output logic r_ovf, output logic done_after);
      @(negedge clk);
      a = ta; b = tb; start = 1'b1;
      @(posedge clk);
      lat = 1;
      busy_cnt = 0;
      #1;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         lat++;
         #1;
      end
      r_diff = diff;
      r_bw   = borrow_out;
      r_ovf  = get_ovf();
      @(posedge clk);
      #1;
      done_after = done;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      start = 1'b0; a = '0; b = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (diff !== '0) begin errors++; $display("FAIL reset_diff: got %h want 00", diff); end
      checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b want 0", borrow_out); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
      // start held during reset must not launch anything
      start = 1'b1; a = 8'd7; b = 8'd1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy: got %b want 0", busy); end
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      int lat, bc;
      logic [W-1:0] d;
      logic bw, ov, da;
      run_op(8'd5, 8'd3, lat, bc, d, bw, ov, da);
      checks++; if (lat !== W + 1) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, W + 1); end
      checks++; if (bc !== W) begin errors++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, W); end
      checks++; if (d !== 8'h02) begin errors++; $display("FAIL basic_diff_5_3: got %h want 02", d); end
      checks++; if (bw !== 1'b0) begin errors++; $display("FAIL basic_borrow_5_3: got %b want 0", bw); end
      checks++; if (da !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", da); end
      run_op(8'd3, 8'd5, lat, bc, d, bw, ov, da);
      checks++; if (d !== 8'hFE) begin errors++; $display("FAIL basic_diff_3_5: got %h want fe", d); end
      checks++; if (bw !== 1'b1) begin errors++; $display("FAIL basic_borrow_3_5: got %b want 1", bw); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL basic_ovf_3_5: got %b want 0", ov); end
`endif
      // results must hold in IDLE
      repeat (3) @(posedge clk);
      #1;
      checks++; if (diff !== 8'hFE) begin errors++; $display("FAIL basic_hold_diff: got %h want fe", diff); end
   endtask

   task automatic test_ovf_cases;
      int lat, bc;
      logic [W-1:0] d;
      logic bw, ov, da;
      run_op(8'h80, 8'h01, lat, bc, d, bw, ov, da);
      checks++; if (d !== 8'h7F) begin errors++; $display("FAIL ovf_diff_80_01: got %h want 7f", d); end
      checks++; if (bw !== 1'b0) begin errors++; $display("FAIL ovf_borrow_80_01: got %b want 0", bw); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ovf_flag_80_01: got %b want 1", ov); end
`endif
      run_op(8'h00, 8'h00, lat, bc, d, bw, ov, da);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL ovf_diff_00_00: got %h want 00", d); end
      checks++; if (bw !== 1'b0) begin errors++; $display("FAIL ovf_borrow_00_00: got %b want 0", bw); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL ovf_flag_00_00: got %b want 0", ov); end
`endif
   endtask

   task automatic test_random;
      int lat, bc, x, y;
      logic [W-1:0] d;
      logic bw, ov, da;
      for (int i = 0; i < 20; i++) begin
         x = int'($urandom_range(0, 255));
         y = int'($urandom_range(0, 255));
         if (i == 0) begin x = 0;   y = 255; end
         if (i == 1) begin x = 255; y = 0;   end
         if (i == 2) begin x = 127; y = 128; end
         run_op(W'(x), W'(y), lat, bc, d, bw, ov, da);
         checks++; if (d !== m_diff(x, y)) begin errors++; $display("FAIL rand_diff a=%0d b=%0d: got %h want %h", x, y, d, m_diff(x, y)); end
         checks++; if (bw !== m_borrow(x, y)) begin errors++; $display("FAIL rand_borrow a=%0d b=%0d: got %b want %b", x, y, bw, m_borrow(x, y)); end
         checks++; if (lat !== W + 1) begin errors++; $display("FAIL rand_latency a=%0d b=%0d: got %0d want %0d", x, y, lat, W + 1); end
`ifdef SERIAL_SUB_OVF_EN
         checks++; if (ov !== m_ovf(x, y)) begin errors++; $display("FAIL rand_ovf a=%0d b=%0d: got %b want %b", x, y, ov, m_ovf(x, y)); end
`endif
      end
   endtask

   task automatic test_back_to_back;
      int t, g;
      int dt[3];
      int pa[3];
      int pb[3];
      pa = '{9, 4, 255};
      pb = '{4, 9, 255};
      @(negedge clk);
      start = 1'b1; a = W'(pa[0]); b = W'(pb[0]);
      @(posedge clk);
      t = 0;
      #1;
      a = W'($urandom); b = W'($urandom);
      for (int k = 0; k < 3; k++) begin
         g = 0;
         while (!done && g < 40) begin
            @(posedge clk);
            t++; g++;
            #1;
         end
         dt[k] = t;
         checks++; if (diff !== m_diff(pa[k], pb[k])) begin errors++; $display("FAIL b2b_diff_%0d: got %h want %h", k, diff, m_diff(pa[k], pb[k])); end
         checks++; if (borrow_out !== m_borrow(pa[k], pb[k])) begin errors++; $display("FAIL b2b_borrow_%0d: got %b want %b", k, borrow_out, m_borrow(pa[k], pb[k])); end
         if (k < 2) begin
            a = W'(pa[k+1]); b = W'(pb[k+1]);
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         t++;
         #1;
         if (k < 2) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept_%0d: busy got %b want 1", k, busy); end
         end
         a = W'($urandom); b = W'($urandom);
      end
      checks++; if (dt[0] !== W) begin errors++; $display("FAIL b2b_first_done: got edge %0d want %0d", dt[0], W); end
      checks++; if (dt[1] - dt[0] !== W + 1) begin errors++; $display("FAIL b2b_spacing_1: got %0d want %0d", dt[1] - dt[0], W + 1); end
      checks++; if (dt[2] - dt[1] !== W + 1) begin errors++; $display("FAIL b2b_spacing_2: got %0d want %0d", dt[2] - dt[1], W + 1); end
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got done=%b busy=%b want 0 0", done, busy); end
   endtask

   task automatic test_ignore_start;
      int pulses;
      logic [W-1:0] cap;
      pulses = 0;
      cap = '0;
      @(negedge clk);
      start = 1'b1; a = 8'd20; b = 8'd7;
      @(posedge clk);
      #1;
      start = 1'b0; a = W'($urandom); b = W'($urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      start = 1'b1; a = 8'd1; b = 8'd2;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            pulses++;
            cap = diff;
         end
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
      checks++; if (cap !== 8'd13) begin errors++; $display("FAIL ignore_diff: got %0d want 13", cap); end
      checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL ignore_borrow: got %b want 0", borrow_out); end
   endtask

   task automatic test_reset_mid_run;
      int pulses, lat, bc;
      logic [W-1:0] d;
      logic bw, ov, da;
      pulses = 0;
      @(negedge clk);
      start = 1'b1; a = 8'd50; b = 8'd60;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
      checks++; if (diff !== 8'd13) begin errors++; $display("FAIL midrst_pre_diff: got %0d want 13", diff); end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
      checks++; if (diff !== '0) begin errors++; $display("FAIL midrst_diff: got %h want 00", diff); end
      checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL midrst_borrow: got %b want 0", borrow_out); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b want 0", ovf); end
`endif
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", pulses); end
      checks++; if (diff !== '0) begin errors++; $display("FAIL midrst_diff_after: got %h want 00", diff); end
      run_op(8'd100, 8'd1, lat, bc, d, bw, ov, da);
      checks++; if (d !== 8'd99) begin errors++; $display("FAIL midrst_next_diff: got %0d want 99", d); end
      checks++; if (bw !== 1'b0) begin errors++; $display("FAIL midrst_next_borrow: got %b want 0", bw); end
      checks++; if (lat !== W + 1) begin errors++; $display("FAIL midrst_next_latency: got %0d want %0d", lat, W + 1); end
   endtask

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      test_reset();
      test_basic();
      test_ovf_cases();
      test_random();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
